// File: rtl/snn_encoder_pkg.sv
// Shared types for the rank-order spike encoder.
package snn_encoder_pkg;

    localparam int DEF_IMAGE_SIZE      = 256;
    localparam int DEF_IMAGE_SIZE_BITS = 8;
    localparam int DEF_PIXEL_MAX_VALUE = 255;
    localparam int DEF_PIXEL_BITS      = 8;
    localparam int DEF_MIN_LEVEL       = 1;

    typedef enum logic [2:0] {IDLE, LOAD, SCAN, EMIT, DONE} enc_state_t;

    typedef logic [DEF_PIXEL_BITS-1:0]      pixel_t;
    typedef logic [DEF_IMAGE_SIZE_BITS-1:0] pixel_idx_t;

endpackage

// File: rtl/level_index_counter.sv
// Nested scan counter: index runs fastest, level counts down from the brightest value.
module level_index_counter #(
    parameter int IMAGE_SIZE      = 256,
    parameter int IMAGE_SIZE_BITS = 8,
    parameter int PIXEL_MAX_VALUE = 255,
    parameter int PIXEL_BITS      = 8,
    parameter int MIN_LEVEL       = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_load,
    input  logic                       i_advance,
    output logic [IMAGE_SIZE_BITS-1:0] o_idx,
    output logic [PIXEL_BITS-1:0]      o_level,
    output logic                       o_last
);

    localparam logic [IMAGE_SIZE_BITS-1:0] IDX_LAST  = IMAGE_SIZE_BITS'(IMAGE_SIZE - 1);
    localparam logic [PIXEL_BITS-1:0]      LEVEL_TOP = PIXEL_BITS'(PIXEL_MAX_VALUE);
    localparam logic [PIXEL_BITS-1:0]      LEVEL_MIN = PIXEL_BITS'(MIN_LEVEL);

    logic w_idx_wrap;

    assign w_idx_wrap = (o_idx == IDX_LAST);
    // Terminal test happens before any decrement, so level never drops below MIN_LEVEL.
    assign o_last     = w_idx_wrap && (o_level == LEVEL_MIN);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_idx   <= '0;
            o_level <= '0;
        end else if (i_load) begin
            o_idx   <= '0;
            o_level <= LEVEL_TOP;
        end else if (i_advance) begin
            if (w_idx_wrap) begin
                o_idx <= '0;
                if (!o_last) begin
                    o_level <= o_level - 1'b1;
                end
            end else begin
                o_idx <= o_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rank_order_encoder.sv
// Snapshots an image on a NEW_IMAGE rising edge and streams pixel addresses brightest-first.
// IDLE wait | LOAD snapshot | SCAN compare one pixel | EMIT hold spike for handshake | DONE pulse
module rank_order_encoder
    import snn_encoder_pkg::*;
#(
    parameter int IMAGE_SIZE      = DEF_IMAGE_SIZE,
    parameter int IMAGE_SIZE_BITS = DEF_IMAGE_SIZE_BITS,
    parameter int PIXEL_MAX_VALUE = DEF_PIXEL_MAX_VALUE,
    parameter int PIXEL_BITS      = DEF_PIXEL_BITS,
    parameter int MIN_LEVEL       = DEF_MIN_LEVEL
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [PIXEL_BITS-1:0]      IMAGE [0:IMAGE_SIZE-1],
    input  logic                       NEW_IMAGE,
    output logic [IMAGE_SIZE_BITS-1:0] SPIKE_ADDR,
    output logic [PIXEL_BITS-1:0]      SPIKE_LEVEL,
    output logic                       SPIKE_VALID,
    input  logic                       SPIKE_READY,
    output logic                       ENCODER_BUSY,
    output logic                       ENCODE_DONE,
    output logic                       OVERRUN
);

    enc_state_t                 r_state;
    enc_state_t                 w_next;
    logic                       r_nimg_q;
    logic                       r_armed;
    logic                       w_start;
    logic                       w_load;
    logic                       w_advance;
    logic                       w_last;
    logic                       w_hit;
    logic [IMAGE_SIZE_BITS-1:0] w_idx;
    logic [PIXEL_BITS-1:0]      w_level;
    logic [PIXEL_BITS-1:0]      r_buf [0:IMAGE_SIZE-1];

    // r_armed blocks the first post-reset cycle, so a NEW_IMAGE held high through reset is not an edge.
    assign w_start = NEW_IMAGE & ~r_nimg_q & r_armed;
    assign w_hit   = (r_buf[w_idx] == w_level);

    level_index_counter #(
        .IMAGE_SIZE      (IMAGE_SIZE),
        .IMAGE_SIZE_BITS (IMAGE_SIZE_BITS),
        .PIXEL_MAX_VALUE (PIXEL_MAX_VALUE),
        .PIXEL_BITS      (PIXEL_BITS),
        .MIN_LEVEL       (MIN_LEVEL)
    ) u_counter (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_load    (w_load),
        .i_advance (w_advance),
        .o_idx     (w_idx),
        .o_level   (w_level),
        .o_last    (w_last)
    );

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) w_next = LOAD;
            end
            LOAD: begin
                w_load = 1'b1;
                w_next = SCAN;
            end
            SCAN: begin
                if (w_hit) begin
                    w_next = EMIT;
                end else begin
                    w_advance = 1'b1;
                    w_next    = w_last ? DONE : SCAN;
                end
            end
            EMIT: begin
                if (SPIKE_READY) begin
                    w_advance = 1'b1;
                    w_next    = w_last ? DONE : SCAN;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_nimg_q     <= 1'b0;
            r_armed      <= 1'b0;
            SPIKE_ADDR   <= '0;
            SPIKE_LEVEL  <= '0;
            SPIKE_VALID  <= 1'b0;
            ENCODER_BUSY <= 1'b0;
            ENCODE_DONE  <= 1'b0;
            OVERRUN      <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_nimg_q     <= NEW_IMAGE;
            r_armed      <= 1'b1;
            SPIKE_VALID  <= (w_next == EMIT);
            ENCODER_BUSY <= (w_next == LOAD) || (w_next == SCAN) || (w_next == EMIT);
            ENCODE_DONE  <= (w_next == DONE);
            if (w_start && (r_state != IDLE)) begin
                OVERRUN <= 1'b1;
            end
            if ((r_state == SCAN) && w_hit) begin
                SPIKE_ADDR  <= w_idx;
                SPIKE_LEVEL <= w_level;
            end
        end
    end

    // The snapshot is only written in LOAD, so a mid-stream edge cannot disturb it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < IMAGE_SIZE; i++) begin
                r_buf[i] <= '0;
            end
        end else if (r_state == LOAD) begin
            for (int i = 0; i < IMAGE_SIZE; i++) begin
                r_buf[i] <= IMAGE[i];
            end
        end
    end

endmodule

// File: tb/tb_rank_order_encoder.sv
// Self-checking bench for rank_order_encoder on a reduced 32-pixel image with full 8-bit levels.
module tb_rank_order_encoder;

    localparam int IS   = 32;
    localparam int ISB  = 5;
    localparam int PMAX = 255;
    localparam int PB   = 8;
    localparam int MINL = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [PB-1:0]   image [0:IS-1];
    logic            new_image;
    logic            spike_ready;
    logic [ISB-1:0]  spike_addr;
    logic [PB-1:0]   spike_level;
    logic            spike_valid;
    logic            busy;
    logic            done;
    logic            overrun;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [ISB-1:0] addr;
        logic [PB-1:0]  level;
    } spike_t;

    typedef struct {
        int kind;
        int stall;
        int ovr_at;
        int exp_nspk;
        bit exp_ovr;
    } vec_t;

    spike_t        sb[$];
    vec_t          vecs [0:4];
    logic [PB-1:0] imgs [0:2][0:IS-1];

    rank_order_encoder #(
        .IMAGE_SIZE      (IS),
        .IMAGE_SIZE_BITS (ISB),
        .PIXEL_MAX_VALUE (PMAX),
        .PIXEL_BITS      (PB),
        .MIN_LEVEL       (MINL)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .IMAGE        (image),
        .NEW_IMAGE    (new_image),
        .SPIKE_ADDR   (spike_addr),
        .SPIKE_LEVEL  (spike_level),
        .SPIKE_VALID  (spike_valid),
        .SPIKE_READY  (spike_ready),
        .ENCODER_BUSY (busy),
        .ENCODE_DONE  (done),
        .OVERRUN      (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference order: level descending, index ascending, nothing below MINL.
    task automatic build_expected(input int kind);
        spike_t s;
        sb.delete();
        for (int lvl = PMAX; lvl >= MINL; lvl--) begin
            for (int i = 0; i < IS; i++) begin
                if (int'(imgs[kind][i]) == lvl) begin
                    s.addr  = ISB'(i);
                    s.level = PB'(lvl);
                    sb.push_back(s);
                end
            end
        end
    endtask

    task automatic run_image(input int vi);
        int     c, nacc, stalled, nspk, exp_first, exp_done, budget, kind, stall, ovr_at, exp_n;
        bit     first_seen, done_seen;
        spike_t e;
        kind   = vecs[vi].kind;
        stall  = vecs[vi].stall;
        ovr_at = vecs[vi].ovr_at;
        build_expected(kind);
        nspk      = sb.size();
        exp_n     = (vecs[vi].exp_nspk >= 0) ? vecs[vi].exp_nspk : nspk;
        exp_first = (nspk > 0) ? 3 + (PMAX - int'(sb[0].level)) * IS + int'(sb[0].addr) : -1;
        exp_done  = 2 + (PMAX - MINL + 1) * IS + nspk + stall;
        budget    = exp_done + 20;
        c = 0; nacc = 0; stalled = 0; first_seen = 0; done_seen = 0;
        for (int i = 0; i < IS; i++) image[i] = imgs[kind][i];
        new_image   = 1'b0;
        spike_ready = 1'b1;
        @(negedge clk);
        new_image = 1'b1;
        while (!done_seen && c < budget) begin
            @(negedge clk);
            c++;
            if (c == 1) chk("busy_after_start", busy, 1);
            if (ovr_at > 0 && c == ovr_at) begin
                for (int i = 0; i < IS; i++) image[i] = 8'd200;
                new_image = 1'b0;
            end
            if (ovr_at > 0 && c == ovr_at + 1) new_image = 1'b1;
            if (spike_valid) begin
                if (!first_seen) begin
                    first_seen = 1;
                    chk("first_valid_cycle", c, exp_first);
                end
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_spike addr=%0d level=%0d required=none", spike_addr, spike_level);
                    spike_ready = 1'b1;
                end else if (nacc == 0 && stalled < stall) begin
                    spike_ready = 1'b0;
                    stalled++;
                    chk("stall_addr_stable", spike_addr, sb[0].addr);
                    chk("stall_level_stable", spike_level, sb[0].level);
                end else begin
                    spike_ready = 1'b1;
                    e = sb.pop_front();
                    chk("spike_addr", spike_addr, e.addr);
                    chk("spike_level", spike_level, e.level);
                    nacc++;
                end
            end else begin
                spike_ready = 1'b1;
            end
            if (done) begin
                done_seen = 1;
                chk("done_cycle", c, exp_done);
            end
        end
        if (!done_seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done_after_%0d required=%0d", c, exp_done);
        end
        @(negedge clk);
        chk("done_pulse_width", done, 0);
        chk("busy_after_done", busy, 0);
        chk("valid_after_done", spike_valid, 0);
        chk("spike_count", nacc, exp_n);
        chk("missing_spikes", sb.size(), 0);
        chk("overrun_flag", overrun, vecs[vi].exp_ovr);
    endtask

    initial begin : main
        logic [31:0] s;
        bit          bad;
        s = 32'h1ACE_B00C;
        for (int i = 0; i < IS; i++) begin
            imgs[0][i] = 8'd0;
            imgs[1][i] = 8'd0;
            s = s ^ (s << 13);
            s = s ^ (s >> 17);
            s = s ^ (s << 5);
            imgs[2][i] = (s[3:0] < 4'd4) ? 8'd0 : s[15:8];
        end
        imgs[0][0] = 8'd255;
        imgs[0][1] = 8'd3;
        imgs[0][5] = 8'd255;
        imgs[2][9]  = imgs[2][4];
        imgs[2][30] = 8'd1;
        imgs[2][31] = 8'd255;

        vecs[0] = '{kind: 0, stall: 0,  ovr_at: 0,  exp_nspk: 3,  exp_ovr: 1'b0};
        vecs[1] = '{kind: 0, stall: 10, ovr_at: 0,  exp_nspk: 3,  exp_ovr: 1'b0};
        vecs[2] = '{kind: 1, stall: 0,  ovr_at: 0,  exp_nspk: 0,  exp_ovr: 1'b0};
        vecs[3] = '{kind: 2, stall: 0,  ovr_at: 0,  exp_nspk: -1, exp_ovr: 1'b0};
        vecs[4] = '{kind: 0, stall: 0,  ovr_at: 20, exp_nspk: 3,  exp_ovr: 1'b1};

        rst = 1'b1;
        new_image = 1'b0;
        spike_ready = 1'b1;
        for (int i = 0; i < IS; i++) image[i] = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_valid", spike_valid, 0);
        chk("reset_addr", spike_addr, 0);
        chk("reset_level", spike_level, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_overrun", overrun, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            run_image(v);
        end

        // Reset while a spike is held in EMIT, with NEW_IMAGE kept high across reset.
        for (int i = 0; i < IS; i++) image[i] = imgs[0][i];
        new_image   = 1'b0;
        spike_ready = 1'b0;
        @(negedge clk);
        new_image = 1'b1;
        for (int c = 0; c < 20 && !spike_valid; c++) @(negedge clk);
        chk("rst_test_emit_reached", spike_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", spike_valid, 0);
        chk("async_rst_addr", spike_addr, 0);
        chk("async_rst_level", spike_level, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_overrun", overrun, 0);
        #1 rst = 1'b0;
        spike_ready = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (spike_valid || busy) bad = 1;
        end
        chk("no_restart_on_held_level", bad, 0);

        run_image(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
